// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
//   MemOp           : load/store sizing code carried on i_dm_op_data
//   DmFaultCause_t  : {oor, mis} fault cause bits
//   mem_byte_en()   : byte-lane enables for a given op and address offset
package data_mem_responder_pkg;

  typedef enum logic [2:0] {
    MemB  = 3'b000,
    MemH  = 3'b001,
    MemW  = 3'b010,
    MemBU = 3'b100,
    MemHU = 3'b101
  } MemOp;

  typedef struct packed {
    logic oor;  // bit 1: out of range
    logic mis;  // bit 0: misaligned
  } DmFaultCause_t;

  // Unsigned variants size like their signed counterparts; unknown codes size as a word.
  function automatic logic [3:0] mem_byte_en(input logic [2:0] op, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (op)
      MemB, MemBU: be = 4'b0001 << addr_lo;
      MemH, MemHU: be = 4'b0011 << addr_lo;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Execute-stage data memory bus.
//   master : the core; drives address, strobes, op, store data and fault clear
//   slave  : the memory responder; returns load data and the sticky fault state
interface data_mem_responder_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] i_dm_addr;
  logic            i_dm_wvalid;
  logic            i_dm_rvalid;
  logic [2:0]      i_dm_op_data;
  logic [XLEN-1:0] i_dm_wdata;
  logic [XLEN-1:0] o_dm_rdata;
  logic            o_fault;
  logic [1:0]      o_fault_cause;
  logic [XLEN-1:0] o_fault_addr;
  logic            i_fault_clr;

  modport master (
    output i_dm_addr, i_dm_wvalid, i_dm_rvalid, i_dm_op_data, i_dm_wdata, i_fault_clr,
    input  o_dm_rdata, o_fault, o_fault_cause, o_fault_addr
  );

  modport slave (
    input  i_dm_addr, i_dm_wvalid, i_dm_rvalid, i_dm_op_data, i_dm_wdata, i_fault_clr,
    output o_dm_rdata, o_fault, o_fault_cause, o_fault_addr
  );
endinterface

// File: rtl/data_mem_responder_dm_lane_steer.sv
// dm_lane_steer: combinational byte-lane steering for the data memory.
//   op, addr_lo : access size code and byte offset within the word
//   wdata       : right-justified store data
//   rword       : raw RAM word at the addressed index
//   byte_en     : lanes written by a store
//   wword       : store data moved into its lanes
//   rshift      : addressed bytes right-justified (upper bits unmasked)
//   mis         : access is misaligned for its size
module dm_lane_steer
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] wword,
  output logic [XLEN-1:0] rshift,
  output logic            mis
);

  always_comb begin
    byte_en = mem_byte_en(op, addr_lo);
    wword   = wdata << {addr_lo, 3'b000};
    rshift  = rword >> {addr_lo, 3'b000};
    case (op)
      MemB, MemBU: mis = 1'b0;
      MemH, MemHU: mis = addr_lo[0];
      default:     mis = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data RAM at the responder end of the
// execute-stage data memory bus, with a sticky fault capture register.
//   i_clk, i_rst : single clock; synchronous active-high reset (fault register only)
//   dm           : data_mem_responder_if.slave bus (address, strobes, op,
//                  store/load data, fault flag/cause/address, fault clear)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = "dmem.hex"
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  data_mem_responder_if.slave   dm
);

  localparam int unsigned     IDXW       = $clog2(DEPTH);
  localparam logic [XLEN:0]   BYTE_LIMIT = (XLEN+1)'(DEPTH * 4);

  logic [XLEN-1:0] mem [DEPTH];

  logic [IDXW-1:0] idx;
  logic [3:0]      byte_en;
  logic [XLEN-1:0] wword;
  logic [XLEN-1:0] rshift;
  logic            mis;
  logic            oor;
  logic            illegal;
  logic            fault_evt;

  DmFaultCause_t   fault_cause_q;
  logic            fault_q;
  logic [XLEN-1:0] fault_addr_q;

  assign idx       = dm.i_dm_addr[IDXW+1:2];
  assign oor       = ({1'b0, dm.i_dm_addr} >= BYTE_LIMIT);
  assign illegal   = mis | oor;
  assign fault_evt = (dm.i_dm_wvalid | dm.i_dm_rvalid) & illegal;

  dm_lane_steer #(.XLEN(XLEN)) u_steer (
    .op      (dm.i_dm_op_data),
    .addr_lo (dm.i_dm_addr[1:0]),
    .wdata   (dm.i_dm_wdata),
    .rword   (mem[idx]),
    .byte_en (byte_en),
    .wword   (wword),
    .rshift  (rshift),
    .mis     (mis)
  );

  // Read path is purely combinational and sees the pre-edge array (no forwarding).
  assign dm.o_dm_rdata = illegal ? '0 : rshift;

  // Array writes ignore reset.
  always_ff @(posedge i_clk) begin
    if (dm.i_dm_wvalid && !illegal) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
      end
    end
  end

  // First fault is held; a clear coinciding with a new fault captures the new one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fault_q       <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
    end else if (fault_evt && (!fault_q || dm.i_fault_clr)) begin
      fault_q       <= 1'b1;
      fault_cause_q <= '{oor: oor, mis: mis};
      fault_addr_q  <= dm.i_dm_addr;
    end else if (dm.i_fault_clr) begin
      fault_q       <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
    end
  end

  assign dm.o_fault       = fault_q;
  assign dm.o_fault_cause = fault_cause_q;
  assign dm.o_fault_addr  = fault_addr_q;

  a_legal_op: assert property (@(posedge i_clk) disable iff (i_rst)
      (dm.i_dm_wvalid || dm.i_dm_rvalid) |->
      (dm.i_dm_op_data inside {MemB, MemH, MemW, MemBU, MemHU}))
    else $warning("illegal MemOp %b sized as MemW", dm.i_dm_op_data);

endmodule
